// File: rtl/button_press_decoder.sv
// Push-button front end: 2-FF synchroniser, polarity fix, counter debounce,
// and a press-duration classifier emitting short/long press events.
module button_press_decoder #(
    parameter int unsigned DEBOUNCE_CYCLES   = 1000000,
    parameter int unsigned LONG_PRESS_CYCLES = 50000000,
    parameter bit          BTN_ACTIVE_LOW    = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_in,
    output logic       btn_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       short_press,
    output logic       long_press,
    output logic       long_hold,
    output logic [7:0] press_count
);

    localparam int unsigned DEB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned HOLD_W = $clog2(LONG_PRESS_CYCLES);
    localparam logic [DEB_W-1:0]  DEB_MAX      = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX     = HOLD_W'(LONG_PRESS_CYCLES - 1);
    localparam logic              PIN_RELEASED = BTN_ACTIVE_LOW;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESSED   = 2'd1,
        LONG_HELD = 2'd2
    } state_t;

    logic              sync1, sync2;
    logic              sync_p;
    logic [DEB_W-1:0]  deb_cnt;
    logic              deb_done_c;
    logic              rise_c;
    logic              fall_c;

    state_t            state, state_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    logic              short_nxt, long_nxt, long_hold_nxt;
    logic [7:0]        count_nxt;

    // Synchroniser flops reset to the released pin level so reset never looks like a press
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= PIN_RELEASED;
            sync2 <= PIN_RELEASED;
        end else begin
            sync1 <= btn_in;
            sync2 <= sync1;
        end
    end

    assign sync_p = sync2 ^ BTN_ACTIVE_LOW;

    // A level is accepted once it has differed from btn_level for DEBOUNCE_CYCLES samples
    assign deb_done_c = (sync_p != btn_level) && (deb_cnt == DEB_MAX);
    assign rise_c     = deb_done_c &  sync_p;
    assign fall_c     = deb_done_c & ~sync_p;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_cnt       <= '0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press_pulse   <= rise_c;
            release_pulse <= fall_c;
            if (sync_p == btn_level) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_MAX) begin
                btn_level <= sync_p;
                deb_cnt   <= '0;
            end else begin
                deb_cnt <= deb_cnt + DEB_W'(1);
            end
        end
    end

    // State register plus registered classifier outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            hold_cnt    <= '0;
            short_press <= 1'b0;
            long_press  <= 1'b0;
            long_hold   <= 1'b0;
            press_count <= '0;
        end else begin
            state       <= state_nxt;
            hold_cnt    <= hold_nxt;
            short_press <= short_nxt;
            long_press  <= long_nxt;
            long_hold   <= long_hold_nxt;
            press_count <= count_nxt;
        end
    end

    // Next state; release is checked before the long threshold so it wins a tie
    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        case (state)
            IDLE: begin
                if (rise_c) begin
                    state_nxt = PRESSED;
                    hold_nxt  = '0;
                end
            end
            PRESSED: begin
                if (fall_c) begin
                    state_nxt = IDLE;
                end else if (hold_cnt == HOLD_MAX) begin
                    state_nxt = LONG_HELD;
                end else begin
                    hold_nxt = hold_cnt + HOLD_W'(1);
                end
            end
            LONG_HELD: begin
                if (fall_c) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        short_nxt     = 1'b0;
        long_nxt      = 1'b0;
        long_hold_nxt = long_hold;
        count_nxt     = press_count;
        case (state)
            IDLE: begin
                if (rise_c) begin
                    count_nxt = press_count + 8'd1;
                end
            end
            PRESSED: begin
                if (fall_c) begin
                    short_nxt = 1'b1;
                end else if (hold_cnt == HOLD_MAX) begin
                    long_nxt      = 1'b1;
                    long_hold_nxt = 1'b1;
                end
            end
            LONG_HELD: begin
                if (fall_c) begin
                    long_hold_nxt = 1'b0;
                end
            end
            default: begin
                long_hold_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_button_press_decoder.sv
// Randomised and directed bench for button_press_decoder against an
// event-level model of debounce and press classification.
module tb_button_press_decoder;

    localparam int unsigned D  = 4;
    localparam int unsigned L  = 20;
    localparam bit          AL = 1'b1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_in = 1'b1;
    logic       btn_level, press_pulse, release_pulse;
    logic       short_press, long_press, long_hold;
    logic [7:0] press_count;

    always #5 clk = ~clk;

    button_press_decoder #(
        .DEBOUNCE_CYCLES  (D),
        .LONG_PRESS_CYCLES(L),
        .BTN_ACTIVE_LOW   (AL)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_in       (btn_in),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .short_press  (short_press),
        .long_press   (long_press),
        .long_hold    (long_hold),
        .press_count  (press_count)
    );

    int n_pass = 0;
    int n_chk  = 0;

    // Model: pressed-samples history, accepted level and per-press bookkeeping
    logic [D:0] m_hist;
    logic       m_stable, m_press, m_rel, m_short, m_long, m_lh, m_done;
    int         m_el;
    logic [7:0] m_cnt;

    // Event monitor
    int cyc = 0;
    int press_cyc, rel_cyc, short_cyc, long_cyc;
    int n_press = 0, n_rel = 0, n_short = 0, n_long = 0;
    logic lvl_seen, lh_seen;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic model_reset();
        m_hist = '0; m_stable = 1'b0; m_press = 1'b0; m_rel = 1'b0;
        m_short = 1'b0; m_long = 1'b0; m_lh = 1'b0; m_done = 1'b0;
        m_el = 0; m_cnt = 8'd0;
    endtask

    // A new level is accepted once the D synchronised samples seen by this edge
    // (pin samples taken 2..D+1 edges ago) all disagree with the accepted level.
    task automatic model_step(input logic pin);
        logic p;
        p = AL ? ~pin : pin;
        m_press = 1'b0; m_rel = 1'b0; m_short = 1'b0; m_long = 1'b0;
        if (m_hist[D:1] == {D{~m_stable}}) begin
            m_stable = ~m_stable;
            if (m_stable) begin
                m_press = 1'b1; m_cnt = m_cnt + 8'd1; m_el = 0; m_done = 1'b0;
            end else begin
                m_rel = 1'b1; m_short = ~m_done; m_lh = 1'b0;
            end
        end else if (m_stable && !m_done) begin
            m_el++;
            if (m_el == int'(L)) begin
                m_long = 1'b1; m_done = 1'b1; m_lh = 1'b1;
            end
        end
        m_hist = {m_hist[D-1:0], p};
    endtask

    // One clock: advance model at the edge, compare 1 time unit later
    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step(btn_in);
        #1;
        cyc++;
        if (rst_n)
            chk("cycle_model",
                int'({btn_level, press_pulse, release_pulse, short_press, long_press, long_hold, press_count}),
                int'({m_stable, m_press, m_rel, m_short, m_long, m_lh, m_cnt}));
        if (press_pulse)   begin press_cyc = cyc; n_press++; end
        if (release_pulse) begin rel_cyc   = cyc; n_rel++;   end
        if (short_press)   begin short_cyc = cyc; n_short++; end
        if (long_press)    begin long_cyc  = cyc; n_long++;  end
        lvl_seen = lvl_seen | btn_level;
        lh_seen  = lh_seen | long_hold;
    endtask

    task automatic hold(input logic v, input int n);
        btn_in = v;
        repeat (n) tick();
    endtask

    initial begin
        int first, s0, l0, r0, p0;
        model_reset();
        lvl_seen = 1'b0; lh_seen = 1'b0;
        press_cyc = 0; rel_cyc = 0; short_cyc = 0; long_cyc = 0;

        // Reset with button released
        rst_n = 1'b0; btn_in = 1'b1;
        repeat (5) tick();
        chk("reset_outputs",
            int'({btn_level, press_pulse, release_pulse, short_press, long_press, long_hold, press_count}), 0);
        rst_n = 1'b1;
        repeat (50) tick();
        chk("idle_no_pulses", n_press + n_rel + n_short + n_long, 0);

        // Clean short press
        first = cyc + 1;
        hold(1'b0, 10);
        chk("press_latency_edges", press_cyc - first + 1, 6);
        chk("press_count_after_first", int'(press_count), 1);
        hold(1'b1, 10);
        chk("short_count", n_short, 1);
        chk("short_with_release", short_cyc - rel_cyc, 0);
        chk("no_long_on_short", n_long, 0);

        // Bounce rejection
        lvl_seen = 1'b0; p0 = n_press; r0 = n_rel;
        for (int i = 0; i < 15; i++) hold(i[0], 2);
        hold(1'b1, 10);
        chk("bounce_level_low", int'(lvl_seen), 0);
        chk("bounce_no_pulses", (n_press - p0) + (n_rel - r0), 0);
        chk("bounce_count_kept", int'(press_count), 1);

        // Long press
        l0 = n_long; s0 = n_short; r0 = n_rel;
        hold(1'b0, 40);
        chk("long_after_press", long_cyc - press_cyc, 20);
        chk("long_once", n_long - l0, 1);
        chk("long_hold_set", int'(long_hold), 1);
        hold(1'b1, 10);
        chk("long_hold_cleared", int'(long_hold), 0);
        chk("long_no_short", n_short - s0, 0);
        chk("long_release_once", n_rel - r0, 1);

        // Boundary: debounced release lands on the threshold cycle
        l0 = n_long; s0 = n_short; lh_seen = 1'b0;
        hold(1'b0, 20);
        hold(1'b1, 10);
        chk("boundary_release_offset", rel_cyc - press_cyc, 20);
        chk("boundary_short", n_short - s0, 1);
        chk("boundary_no_long", n_long - l0, 0);
        chk("boundary_no_long_hold", int'(lh_seen), 0);

        // Async reset while long-held
        hold(1'b0, 30);
        chk("pre_reset_long_hold", int'(long_hold), 1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_long_hold", int'(long_hold), 0);
        chk("async_reset_level", int'(btn_level), 0);
        chk("async_reset_count", int'(press_count), 0);
        btn_in = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (5) tick();

        // 256 presses wrap the counter
        p0 = n_press;
        for (int i = 0; i < 256; i++) begin
            hold(1'b0, 8);
            hold(1'b1, 8);
        end
        chk("wrap_presses", n_press - p0, 256);
        chk("wrap_count_zero", int'(press_count), 0);

        // Random pin activity with occasional resets
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                rst_n = 1'b0;
                repeat (2) tick();
                rst_n = 1'b1;
            end
            hold(1'($urandom_range(0, 1)), int'($urandom_range(1, 28)));
        end
        hold(1'b1, 20);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
